// File: rtl/vga_pkg.sv
// Shared types and sizes for the 8-cell VGA test-pattern controller.
package vga_pkg;

    localparam int NCELLS = 8;
    localparam int CELL_W = 3;
    localparam int RGB_W  = 3;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ctrl_state_t;

    function automatic rgb_t rgb_invert(input rgb_t c);
        return ~c;
    endfunction

endpackage

// File: rtl/vga_btn_debounce.sv
// Two-flop synchroniser, stability debouncer and one-cycle press pulse
// for one active-low asynchronous button.
module vga_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchroniser; resets to the released level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], btn_n};
        end
    end

    // Accept a level only after it has differed from stable for the full window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_r <= 1'b1;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else if (sync_r[1] != stable_r) begin
            if (cnt_r == CNT_LAST) begin
                stable_r <= sync_r[1];
                cnt_r    <= '0;
                press_r  <= ~sync_r[1];
            end else begin
                stable_r <= stable_r;
                cnt_r    <= cnt_r + CNT_ONE;
                press_r  <= 1'b0;
            end
        end else begin
            stable_r <= stable_r;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/vga_cell_ctrl.sv
// Cursor, frame-synchronous palette commit, cursor blink and registered
// pixel output for the 8-cell VGA test pattern.
module vga_cell_ctrl
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int BLINK_FRAMES    = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next_n,
    input  logic              btn_commit_n,
    input  logic [RGB_W-1:0]  sw_rgb_n,
    input  logic              frame_start,
    input  logic              in_display,
    input  logic [CELL_W-1:0] cell_idx,
    output logic [RGB_W-1:0]  pixel,
    output logic [CELL_W-1:0] cursor,
    output logic              pending
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_ARMED = ARMED;

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
    localparam logic [CELL_W-1:0]  CELL_ONE   = CELL_W'(1);

    logic              next_evt_s;
    logic              commit_evt_s;
    logic [RGB_W-1:0]  rgb_meta_r;
    logic [RGB_W-1:0]  rgb_sw_r;
    rgb_t              rgb_sync_s;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    rgb_t              pend_rgb_r;
    rgb_t              pend_rgb_nxt_s;
    logic [CELL_W-1:0] pend_idx_r;
    logic [CELL_W-1:0] pend_idx_nxt_s;
    logic              pal_we_s;
    logic [CELL_W-1:0] pal_widx_s;
    rgb_t              pal_wdata_s;
    rgb_t              palette_r [NCELLS];

    logic [CELL_W-1:0] cursor_r;
    logic              pending_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic              blink_phase_r;
    rgb_t              pix_nxt_s;
    rgb_t              pixel_r;

    vga_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_next (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_next_n),
        .press (next_evt_s)
    );

    vga_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_commit (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_commit_n),
        .press (commit_evt_s)
    );

    // Colour switch synchroniser; only sampled when a commit is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_meta_r <= 3'b111;
            rgb_sw_r   <= 3'b111;
        end else begin
            rgb_meta_r <= sw_rgb_n;
            rgb_sw_r   <= rgb_meta_r;
        end
    end

    assign rgb_sync_s = ~rgb_sw_r;

    // Commit FSM: palette writes are only ever issued on a frame_start cycle.
    always_comb begin
        state_nxt_s    = state_r;
        pend_rgb_nxt_s = pend_rgb_r;
        pend_idx_nxt_s = pend_idx_r;
        pal_we_s       = 1'b0;
        pal_widx_s     = pend_idx_r;
        pal_wdata_s    = pend_rgb_r;
        case (state_r)
            ST_IDLE: begin
                if (commit_evt_s) begin
                    state_nxt_s    = ST_ARMED;
                    pend_rgb_nxt_s = rgb_sync_s;
                    pend_idx_nxt_s = cursor_r;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (frame_start && commit_evt_s) begin
                    // A commit landing on the frame boundary bypasses the pending slot.
                    pal_we_s    = 1'b1;
                    pal_widx_s  = cursor_r;
                    pal_wdata_s = rgb_sync_s;
                    state_nxt_s = ST_IDLE;
                end else if (frame_start) begin
                    pal_we_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (commit_evt_s) begin
                    pend_rgb_nxt_s = rgb_sync_s;
                    pend_idx_nxt_s = cursor_r;
                    state_nxt_s    = ST_ARMED;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, pending commit and the registered pending flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pend_rgb_r <= 3'b000;
            pend_idx_r <= 3'd0;
            pending_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pend_rgb_r <= pend_rgb_nxt_s;
            pend_idx_r <= pend_idx_nxt_s;
            pending_r  <= (state_nxt_s == ST_ARMED);
        end
    end

    // Palette storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCELLS; i++) begin
                palette_r[i] <= 3'b111;
            end
        end else if (pal_we_s) begin
            palette_r[pal_widx_s] <= pal_wdata_s;
        end else begin
            palette_r <= palette_r;
        end
    end

    // Cursor advances on every debounced next press, in any FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor_r <= 3'd0;
        end else if (next_evt_s) begin
            cursor_r <= cursor_r + CELL_ONE;
        end else begin
            cursor_r <= cursor_r;
        end
    end

    // Frame counter and blink phase, independent of the commit FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + BLINK_ONE;
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            blink_cnt_r   <= blink_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    // Pixel colour: blank outside the display, cursor cell inverted in blink phase.
    always_comb begin
        pix_nxt_s = 3'b000;
        if (in_display) begin
            if ((cell_idx == cursor_r) && blink_phase_r) begin
                pix_nxt_s = rgb_invert(palette_r[cell_idx]);
            end else begin
                pix_nxt_s = palette_r[cell_idx];
            end
        end else begin
            pix_nxt_s = 3'b000;
        end
    end

    // Registered pixel output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_r <= 3'b000;
        end else begin
            pixel_r <= pix_nxt_s;
        end
    end

    assign pixel   = pixel_r;
    assign cursor  = cursor_r;
    assign pending = pending_r;

endmodule

// File: tb/tb_vga_cell_ctrl.sv
// Directed self-checking bench for vga_cell_ctrl with short debounce and blink periods.
module tb_vga_cell_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_next_n = 1'b1;
    logic       btn_commit_n = 1'b1;
    logic [2:0] sw_rgb_n = 3'b111;
    logic       frame_start = 1'b0;
    logic       in_display = 1'b0;
    logic [2:0] cell_idx = 3'd0;
    logic [2:0] pixel;
    logic [2:0] cursor;
    logic       pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [2:0] pal_m [8];
    logic [2:0] cur_m;
    logic       ph_m;
    int         fc_m;

    vga_cell_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .BLINK_FRAMES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_next_n   (btn_next_n),
        .btn_commit_n (btn_commit_n),
        .sw_rgb_n     (sw_rgb_n),
        .frame_start  (frame_start),
        .in_display   (in_display),
        .cell_idx     (cell_idx),
        .pixel        (pixel),
        .cursor       (cursor),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_pix(input logic [2:0] idx);
        if (idx == cur_m && ph_m) return ~pal_m[idx];
        return pal_m[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) pal_m[i] = 3'b111;
        cur_m = 3'd0;
        ph_m  = 1'b0;
        fc_m  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        fc_m++;
        if (fc_m == 2) begin
            fc_m = 0;
            ph_m = ~ph_m;
        end
    endtask

    task automatic show_cell(input logic [2:0] idx);
        @(negedge clk);
        in_display = 1'b1;
        cell_idx   = idx;
        @(negedge clk);
        in_display = 1'b0;
    endtask

    task automatic press_next();
        @(negedge clk);
        btn_next_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_next_n = 1'b1;
        repeat (10) @(negedge clk);
        cur_m = cur_m + 3'd1;
    endtask

    task automatic press_commit(input logic [2:0] sw);
        @(negedge clk);
        sw_rgb_n     = sw;
        btn_commit_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_commit_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Press commit so its debounced event lands on the same cycle as frame_start.
    task automatic commit_on_frame(input logic [2:0] sw);
        @(negedge clk);
        sw_rgb_n     = sw;
        btn_commit_n = 1'b0;
        repeat (6) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        fc_m++;
        if (fc_m == 2) begin
            fc_m = 0;
            ph_m = ~ph_m;
        end
    endtask

    task automatic release_commit();
        repeat (4) @(negedge clk);
        btn_commit_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        if (pixel !== 3'b000) begin $display("FAIL reset_pixel got=%b exp=000", pixel); n_fail++; end
        n_tests++;
        if (cursor !== 3'd0) begin $display("FAIL reset_cursor got=%0d exp=0", cursor); n_fail++; end
        n_tests++;
        if (pending !== 1'b0) begin $display("FAIL reset_pending got=%b exp=0", pending); n_fail++; end
        n_tests++;
        for (int i = 0; i < 8; i++) begin
            show_cell(3'(i));
            if (pixel !== 3'b111) begin $display("FAIL reset_cell%0d got=%b exp=111", i, pixel); n_fail++; end
            n_tests++;
        end
        @(negedge clk);
        if (pixel !== 3'b000) begin $display("FAIL blank_pixel got=%b exp=000", pixel); n_fail++; end
        n_tests++;
        frame_pulse();
        frame_pulse();
        show_cell(3'd0);
        if (pixel !== 3'b000) begin $display("FAIL blink_cursor_cell got=%b exp=000", pixel); n_fail++; end
        n_tests++;
        show_cell(3'd1);
        if (pixel !== 3'b111) begin $display("FAIL blink_other_cell got=%b exp=111", pixel); n_fail++; end
        n_tests++;
        frame_pulse();
        frame_pulse();
        show_cell(3'd0);
        if (pixel !== 3'b111) begin $display("FAIL blink_off_cell got=%b exp=111", pixel); n_fail++; end
        n_tests++;
    endtask

    task automatic test_next();
        for (int i = 0; i < 3; i++) press_next();
        if (cursor !== 3'd3) begin $display("FAIL next_x3 got=%0d exp=3", cursor); n_fail++; end
        n_tests++;
        for (int i = 0; i < 5; i++) press_next();
        if (cursor !== 3'd0) begin $display("FAIL next_wrap got=%0d exp=0", cursor); n_fail++; end
        n_tests++;
        @(negedge clk);
        btn_next_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_next_n = 1'b1;
        repeat (10) @(negedge clk);
        if (cursor !== 3'd0) begin $display("FAIL next_glitch got=%0d exp=0", cursor); n_fail++; end
        n_tests++;
    endtask

    task automatic test_commit();
        press_next();
        press_next();
        if (cursor !== 3'd2) begin $display("FAIL commit_cursor got=%0d exp=2", cursor); n_fail++; end
        n_tests++;
        press_commit(3'b011);
        if (pending !== 1'b1) begin $display("FAIL commit_pending got=%b exp=1", pending); n_fail++; end
        n_tests++;
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL commit_before_frame got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
        frame_pulse();
        pal_m[2] = 3'b100;
        if (pending !== 1'b0) begin $display("FAIL commit_pending_clr got=%b exp=0", pending); n_fail++; end
        n_tests++;
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL commit_cell2 got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
        show_cell(3'd3);
        if (pixel !== exp_pix(3'd3)) begin $display("FAIL commit_cell3 got=%b exp=%b", pixel, exp_pix(3'd3)); n_fail++; end
        n_tests++;
        frame_pulse();
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL commit_cell2_blink got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
    endtask

    task automatic test_last_wins();
        press_commit(3'b101);
        press_commit(3'b110);
        if (pending !== 1'b1) begin $display("FAIL last_pending got=%b exp=1", pending); n_fail++; end
        n_tests++;
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL last_before_frame got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
        frame_pulse();
        pal_m[2] = 3'b001;
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL last_cell2 got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
        frame_pulse();
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL last_no_late_write got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
    endtask

    task automatic test_simultaneous();
        press_commit(3'b101);
        if (pending !== 1'b1) begin $display("FAIL simul_armed got=%b exp=1", pending); n_fail++; end
        n_tests++;
        commit_on_frame(3'b001);
        pal_m[2] = 3'b110;
        if (pending !== 1'b0) begin $display("FAIL simul_pending got=%b exp=0", pending); n_fail++; end
        n_tests++;
        release_commit();
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL simul_cell2 got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
        // Commit on a frame boundary from IDLE waits for the following frame.
        commit_on_frame(3'b010);
        if (pending !== 1'b1) begin $display("FAIL idle_simul_pending got=%b exp=1", pending); n_fail++; end
        n_tests++;
        release_commit();
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL idle_simul_hold got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
        frame_pulse();
        pal_m[2] = 3'b101;
        if (pending !== 1'b0) begin $display("FAIL idle_simul_clr got=%b exp=0", pending); n_fail++; end
        n_tests++;
        show_cell(3'd2);
        if (pixel !== exp_pix(3'd2)) begin $display("FAIL idle_simul_cell2 got=%b exp=%b", pixel, exp_pix(3'd2)); n_fail++; end
        n_tests++;
    endtask

    task automatic test_reset_pending();
        press_commit(3'b100);
        if (pending !== 1'b1) begin $display("FAIL rstp_armed got=%b exp=1", pending); n_fail++; end
        n_tests++;
        do_reset();
        if (pending !== 1'b0) begin $display("FAIL rstp_pending got=%b exp=0", pending); n_fail++; end
        n_tests++;
        if (cursor !== 3'd0) begin $display("FAIL rstp_cursor got=%0d exp=0", cursor); n_fail++; end
        n_tests++;
        frame_pulse();
        for (int i = 0; i < 8; i++) begin
            show_cell(3'(i));
            if (pixel !== exp_pix(3'(i))) begin $display("FAIL rstp_cell%0d got=%b exp=%b", i, pixel, exp_pix(3'(i))); n_fail++; end
            n_tests++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_next();
        test_commit();
        test_last_wins();
        test_simultaneous();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
